mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one external memory port between instruction fetch (IF) and the MEM stage of the MIPS pipeline.
//  The MEM-stage side is driven by the EXE/MEM pipeline register:
//   - MEM_R_EN / MEM_W_EN select read or write.
//   - ALU_result is the address; ST_val is the write data.
//  Arbitrates, sequences each variable-latency transfer and returns data.
//  Produces the freeze signals that stall the pipeline while a requester waits.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  MAX_WAIT  16  watchdog limit: cycles in a SERVE state without ext_ready (>=2)
// PORTS
//  clk         in   1       clock; all state changes on rising edge
//  rst         in   1       reset, asynchronous, active-low (0 = reset)
//  if_req      in   1       IF read request; held until if_ack
//  if_addr     in   ADDR_W  IF address
//  if_rdata    out  DATA_W  instruction word; valid when if_ack=1
//  if_ack      out  1       one-cycle completion pulse to IF
//  mem_r_en    in   1       MEM-stage read request; held until mem_ack
//  mem_w_en    in   1       MEM-stage write request; held until mem_ack (never with mem_r_en)
//  mem_addr    in   ADDR_W  data address (ALU_result)
//  mem_wdata   in   DATA_W  store data (ST_val)
//  mem_rdata   out  DATA_W  load data; valid when mem_ack=1 after a read
//  mem_ack     out  1       one-cycle completion pulse to MEM stage
//  freeze_if   out  1       if_req & ~if_ack (combinational)
//  freeze_mem  out  1       (mem_r_en|mem_w_en) & ~mem_ack (combinational)
//  ext_req     out  1       external transfer active
//  ext_we      out  1       1 = write
//  ext_addr    out  ADDR_W  external address
//  ext_wdata   out  DATA_W  external write data
//  ext_rdata   in   DATA_W  external read data; sampled when ext_ready=1
//  ext_ready   in   1       transfer complete this cycle
//  err         out  1       sticky watchdog-timeout flag
// BEHAVIOUR
//  - Reset: state=IDLE; last_grant=IF; wait counter=0. All outputs 0: ext_*, acks, rdata, err.
//    Applies immediately, including mid-transfer; ext_req drops asynchronously.
//  - FSM states: IDLE, SERVE_D, SERVE_I.
//  - IDLE, choosing the next grant:
//    - Eligible data = (mem_r_en|mem_w_en) & ~mem_ack. Eligible IF = if_req & ~if_ack.
//      Masking by ack keeps a held request from being re-granted in its ack cycle.
//    - Only one eligible -> grant it.
//    - Both eligible -> data wins unless last_grant=DATA, then IF wins (alternation; no starvation).
//  - On grant: latch addr/we/wdata into ext_* registers; next cycle ext_req=1.
//    ext_* are held stable until completion.
//  - SERVE_x completion: at the edge where ext_ready=1:
//    - Read: capture ext_rdata into x_rdata.
//    - Pulse x_ack=1 for exactly one cycle; drop ext_req; record last_grant; go to IDLE.
//  - Latency: request in cycle 0, ext_req in cycle 1.
//    ext_ready in cycle 1 -> ack in cycle 2 (minimum 2 cycles).
//  - Writes: mem_rdata holds its previous value. if_rdata and mem_rdata hold between acks.
//  - Watchdog:
//    - Counter clears on entry to SERVE_x and increments each cycle without ext_ready.
//    - On reaching MAX_WAIT-1 it completes the transfer as above with rdata = 32'hFFFF_FFFF.
//    - It also sets err=1; err clears only on reset.
//  - ext_ready while ext_req=0 is ignored.
// STRUCTURE
//  Shared package mips_pkg:
//   - FSM state localparams (IDLE=2'd0, SERVE_D=2'd1, SERVE_I=2'd2)
//   - GRANT_IF/GRANT_DATA
//   - TIMEOUT_DATA = 32'hFFFF_FFFF
//  One sub-module, wait_watchdog (clear, count enable, expired output, parameter MAX_WAIT).
//  The arbiter FSM and datapath registers stay in this module.
// TESTING
//  1. IF only: if_addr=0x40; ext_ready high the first cycle ext_req=1, ext_rdata=0x2001000A.
//     -> if_ack in cycle 2, if_rdata=0x2001000A, freeze_if low from cycle 2.
//  2. Simultaneous if_req and mem_r_en (addr 0x100, last_grant=IF) -> data served first.
//     IF served next, and the two ext_req windows are not back-to-back.
//  3. Store: mem_w_en, addr 0x8, wdata 0xCAFEF00D, ext_ready after 3 wait cycles.
//     -> ext_we=1 and addr/wdata stable through wait; mem_ack one cycle; mem_rdata unchanged.
//  4. ext_ready never asserted, MAX_WAIT=16 -> ack at cycle 16 after grant.
//     rdata=0xFFFFFFFF; err=1 and stays 1 until reset.
//  5. rst driven low while ext_req=1 in SERVE_I -> ext_req=0 immediately.
//     After release: state IDLE, no spurious ack; a still-held if_req is re-granted.
//  6. Requester holds req through its ack cycle -> no second transfer.
//     Only one ext_req window per request.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory-port arbiter.
//   - FSM state encodings (IDLE, SERVE_D, SERVE_I)
//   - Grant identifiers used for round-robin alternation
//   - Read data returned when a transfer is abandoned by the watchdog
//   - Helper that decides whether the data side wins arbitration
package mips_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_D = 2'd1;
  localparam logic [1:0] SERVE_I = 2'd2;

  localparam logic GRANT_IF   = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

  // Data wins a tie unless it was the side granted last time.
  function automatic logic pick_data(input logic elig_d, input logic elig_i,
                                     input logic last_grant);
    return elig_d & (~elig_i | (last_grant != GRANT_DATA));
  endfunction

endpackage

// File: rtl/wait_watchdog.sv
// Wait-cycle watchdog for one external transfer.
//   clk_i      clock
//   rst_ni     asynchronous reset, active-low
//   clr_i      hold the counter at zero (asserted while no transfer is active)
//   en_i       count this cycle (transfer active and ext_ready low)
//   expired_o  this is the last wait cycle allowed; the transfer must be closed now
module wait_watchdog #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(MAX_WAIT);
  // Expiry fires in the cycle whose increment would bring the count to MAX_WAIT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign expired_o = en_i & (cnt_q == LIMIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM stage.
//   clk, rst            clock; asynchronous active-low reset
//   if_req/if_addr      IF read request (held until if_ack)
//   if_rdata/if_ack     instruction word and one-cycle completion pulse
//   mem_r_en/mem_w_en   MEM-stage read/write request (held until mem_ack)
//   mem_addr/mem_wdata  data address (ALU result) and store data
//   mem_rdata/mem_ack   load data and one-cycle completion pulse
//   freeze_if/mem       combinational stall for each requester
//   ext_*               external port: req/we/addr/wdata out, rdata/ready in
//   err                 sticky watchdog-timeout flag
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              freeze_if,
  output logic              freeze_mem,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ready,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              ext_req_q, ext_req_d;
  logic              ext_we_q, ext_we_d;
  logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              err_q, err_d;

  logic              elig_d, elig_i, grant_d, grant_i;
  logic              serving, wd_expired, done;
  logic [DATA_W-1:0] cap_data;

  // A request still held in its ack cycle must not be granted again.
  assign elig_d  = (mem_r_en | mem_w_en) & ~mem_ack_q;
  assign elig_i  = if_req & ~if_ack_q;
  assign grant_d = pick_data(elig_d, elig_i, last_grant_q);
  assign grant_i = elig_i & ~grant_d;

  assign serving  = (state_q != IDLE);
  assign done     = serving & (ext_ready | wd_expired);
  assign cap_data = ext_ready ? ext_rdata : DATA_W'(TIMEOUT_DATA);

  wait_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wd (
    .clk_i     (clk),
    .rst_ni    (rst),
    .clr_i     (~serving),
    .en_i      (serving & ~ext_ready),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ext_req_d    = ext_req_q;
    ext_we_d     = ext_we_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = SERVE_D;
          ext_req_d   = 1'b1;
          ext_we_d    = mem_w_en;
          ext_addr_d  = mem_addr;
          ext_wdata_d = mem_wdata;
        end else if (grant_i) begin
          state_d    = SERVE_I;
          ext_req_d  = 1'b1;
          ext_we_d   = 1'b0;
          ext_addr_d = if_addr;
        end
      end
      SERVE_D: begin
        if (done) begin
          state_d      = IDLE;
          ext_req_d    = 1'b0;
          ext_we_d     = 1'b0;
          mem_ack_d    = 1'b1;
          last_grant_d = GRANT_DATA;
          err_d        = err_q | wd_expired;
          // A store leaves the last load value visible.
          if (!ext_we_q) begin
            mem_rdata_d = cap_data;
          end
        end
      end
      SERVE_I: begin
        if (done) begin
          state_d      = IDLE;
          ext_req_d    = 1'b0;
          if_ack_d     = 1'b1;
          last_grant_d = GRANT_IF;
          err_d        = err_q | wd_expired;
          if_rdata_d   = cap_data;
        end
      end
      default: begin
        state_d   = IDLE;
        ext_req_d = 1'b0;
        ext_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_IF;
      ext_req_q    <= 1'b0;
      ext_we_q     <= 1'b0;
      ext_addr_q   <= '0;
      ext_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ext_req_q    <= ext_req_d;
      ext_we_q     <= ext_we_d;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      err_q        <= err_d;
    end
  end

  assign if_rdata   = if_rdata_q;
  assign if_ack     = if_ack_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_ack    = mem_ack_q;
  assign ext_req    = ext_req_q;
  assign ext_we     = ext_we_q;
  assign ext_addr   = ext_addr_q;
  assign ext_wdata  = ext_wdata_q;
  assign err        = err_q;
  assign freeze_if  = if_req & ~if_ack_q;
  assign freeze_mem = (mem_r_en | mem_w_en) & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        freeze_if;
  logic        freeze_mem;
  logic        ext_req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic [31:0] ext_rdata;
  logic        ext_ready;
  logic        err;

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .mem_r_en   (mem_r_en),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .freeze_if  (freeze_if),
    .freeze_mem (freeze_mem),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rdata  (ext_rdata),
    .ext_ready  (ext_ready),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ext_data;
    int          waits;
    logic [31:0] exp_rdata;
    int          exp_lat;
    bit          exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int windows = 0;
  int unstable = 0;
  int if_acks = 0;
  int mem_acks = 0;
  int if_ack_cyc = 0;
  int mem_ack_cyc = 0;
  int req_cyc = 0;
  int srv_cnt = 0;
  int mdl_waits = 0;
  bit mdl_noise = 1'b0;
  bit prev_req = 1'b0;
  bit drop_if = 1'b0;
  bit drop_mem = 1'b0;
  logic [31:0] win_addr = '0;
  logic [31:0] win_wdata = '0;
  logic        win_we = 1'b0;

  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] mem_img [logic [31:0]];

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: requester drop, ext_req window monitor, ack scoreboard, memory model.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (drop_if) begin
      if_req  = 1'b0;
      drop_if = 1'b0;
    end
    if (drop_mem) begin
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      drop_mem = 1'b0;
    end
    if (ext_req && !prev_req) begin
      windows++;
      win_addr  = ext_addr;
      win_we    = ext_we;
      win_wdata = ext_wdata;
    end else if (ext_req && (ext_addr !== win_addr || ext_we !== win_we ||
                             ext_wdata !== win_wdata)) begin
      unstable++;
    end
    prev_req = ext_req;
    if (if_ack) begin
      chk("if_ack_expected", 32'(if_q.size() != 0), 32'd1);
      if (if_q.size() != 0) begin
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e);
      end
      chk("freeze_if_at_ack", 32'(freeze_if), 32'd0);
      if_acks++;
      if_ack_cyc = cyc;
      drop_if = 1'b1;
    end
    if (mem_ack) begin
      chk("mem_ack_expected", 32'(mem_q.size() != 0), 32'd1);
      if (mem_q.size() != 0) begin
        e = mem_q.pop_front();
        chk("mem_rdata", mem_rdata, e);
      end
      chk("freeze_mem_at_ack", 32'(freeze_mem), 32'd0);
      mem_acks++;
      mem_ack_cyc = cyc;
      drop_mem = 1'b1;
    end
    if (!ext_req) begin
      srv_cnt   = 0;
      ext_ready = mdl_noise;
    end else begin
      ext_ready = (mdl_waits >= 0) && (srv_cnt == mdl_waits);
      srv_cnt++;
    end
    ext_rdata = mem_img.exists(ext_addr) ? mem_img[ext_addr] : ~ext_addr;
  endtask

  task automatic wait_acks(input int n_if, input int n_mem, input int budget, input string name);
    int i0 = if_acks;
    int m0 = mem_acks;
    int k = 0;
    while ((if_acks - i0 < n_if || mem_acks - m0 < n_mem) && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_ack_within_budget"},
        32'((if_acks - i0 >= n_if) && (mem_acks - m0 >= n_mem)), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ext_req"},   32'(ext_req), 32'd0);
    chk({tag, "_ext_we"},    32'(ext_we), 32'd0);
    chk({tag, "_ext_addr"},  ext_addr, 32'd0);
    chk({tag, "_ext_wdata"}, ext_wdata, 32'd0);
    chk({tag, "_if_ack"},    32'(if_ack), 32'd0);
    chk({tag, "_mem_ack"},   32'(mem_ack), 32'd0);
    chk({tag, "_if_rdata"},  if_rdata, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    chk({tag, "_err"},       32'(err), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_q.delete();
    mem_q.delete();
    drop_if  = 1'b0;
    drop_mem = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int w0, u0, a0;
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'h2001000A, 0,  32'h2001000A, 2,  1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h12345678, 1,  32'h12345678, 3,  1'b0};
    vecs[2] = '{1'b0, 1'b1, 32'h8,   32'hCAFEF00D, 32'h0BAD0BAD, 3,  32'h12345678, 5,  1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h44,  32'h0,        32'hDEADBEEF, 2,  32'hDEADBEEF, 4,  1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h00000000, 0,  32'h00000000, 2,  1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h300, 32'h0,        32'h55555555, -1, 32'hFFFFFFFF, 16, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h0F0F0F0F, 0,  32'h0F0F0F0F, 2,  1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h108, 32'h0,        32'h00000001, -1, 32'hFFFFFFFF, 16, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 32'h10,  32'h11112222, 32'h0,        0,  32'hFFFFFFFF, 2,  1'b1};

    rst = 1'b0;
    if_req = 1'b0;
    if_addr = '0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    ext_rdata = '0;
    ext_ready = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Table: single-requester transfers, with ext_ready toggling while idle.
    mdl_noise = 1'b1;
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      mem_img[v.addr] = v.ext_data;
      mdl_waits = v.waits;
      w0 = windows;
      u0 = unstable;
      if (v.is_if) begin
        if_addr = v.addr;
        if_req  = 1'b1;
        if_q.push_back(v.exp_rdata);
      end else begin
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_r_en  = ~v.we;
        mem_w_en  = v.we;
        mem_q.push_back(v.exp_rdata);
      end
      req_cyc = cyc;
      #1;
      chk($sformatf("v%0d_freeze", i), 32'(v.is_if ? freeze_if : freeze_mem), 32'd1);
      wait_acks(v.is_if ? 1 : 0, v.is_if ? 0 : 1, 40, $sformatf("v%0d", i));
      chk($sformatf("v%0d_latency", i),
          32'((v.is_if ? if_ack_cyc : mem_ack_cyc) - req_cyc), 32'(v.exp_lat));
      chk($sformatf("v%0d_ext_addr", i), win_addr, v.addr);
      chk($sformatf("v%0d_ext_we", i), 32'(win_we), 32'(v.we));
      if (v.we) chk($sformatf("v%0d_ext_wdata", i), win_wdata, v.wdata);
      tick();
      tick();
      chk($sformatf("v%0d_windows", i), 32'(windows - w0), 32'd1);
      chk($sformatf("v%0d_ext_stable", i), 32'(unstable - u0), 32'd0);
      chk($sformatf("v%0d_err", i), 32'(err), 32'(v.exp_err));
    end
    mdl_noise = 1'b0;

    // Reset clears the sticky error and returns last_grant to IF.
    do_reset();
    check_reset_outputs("rst2");

    // Simultaneous requests with last_grant=IF: data first, then IF, with a gap.
    mem_img[32'h80] = 32'h0A0A0A0A;
    mdl_waits = 0;
    w0 = windows;
    if_addr = 32'h80;
    if_req = 1'b1;
    mem_addr = 32'h100;
    mem_r_en = 1'b1;
    if_q.push_back(32'h0A0A0A0A);
    mem_q.push_back(32'h12345678);
    req_cyc = cyc;
    wait_acks(1, 1, 40, "tie1");
    chk("tie1_mem_first", 32'(mem_ack_cyc - req_cyc), 32'd2);
    chk("tie1_if_second", 32'(if_ack_cyc - req_cyc), 32'd4);
    tick();
    tick();
    chk("tie1_windows", 32'(windows - w0), 32'd2);

    // Data-only read so last_grant=DATA, then a tie must go to IF.
    mem_addr = 32'h104;
    mem_r_en = 1'b1;
    mem_q.push_back(32'h0F0F0F0F);
    wait_acks(0, 1, 40, "pre_tie2");
    tick();
    tick();
    mem_img[32'h84] = 32'h84848484;
    if_addr = 32'h84;
    if_req = 1'b1;
    mem_addr = 32'h200;
    mem_r_en = 1'b1;
    if_q.push_back(32'h84848484);
    mem_q.push_back(32'h00000000);
    req_cyc = cyc;
    wait_acks(1, 1, 40, "tie2");
    chk("tie2_if_first", 32'(if_ack_cyc - req_cyc), 32'd2);
    chk("tie2_mem_second", 32'(mem_ack_cyc - req_cyc), 32'd4);
    tick();
    tick();

    // Reset while an IF transfer is in flight; held if_req is re-granted afterwards.
    mem_img[32'h500] = 32'h50505050;
    mdl_waits = -1;
    if_addr = 32'h500;
    if_req = 1'b1;
    tick();
    tick();
    tick();
    chk("rst_mid_ext_req_before", 32'(ext_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_ext_req_async", 32'(ext_req), 32'd0);
    chk("rst_mid_if_ack", 32'(if_ack), 32'd0);
    if_q.delete();
    tick();
    tick();
    mdl_waits = 0;
    if_q.push_back(32'h50505050);
    req_cyc = cyc;
    a0 = if_acks;
    rst = 1'b1;
    wait_acks(1, 0, 40, "rst_regrant");
    chk("rst_regrant_latency", 32'(if_ack_cyc - req_cyc), 32'd2);
    tick();
    tick();

    // Request held through its ack cycle: exactly one window and one ack.
    mem_img[32'h600] = 32'h60606060;
    mdl_noise = 1'b1;
    w0 = windows;
    a0 = if_acks;
    if_addr = 32'h600;
    if_req = 1'b1;
    if_q.push_back(32'h60606060);
    wait_acks(1, 0, 40, "hold");
    for (int k = 0; k < 6; k++) tick();
    chk("hold_windows", 32'(windows - w0), 32'd1);
    chk("hold_acks", 32'(if_acks - a0), 32'd1);
    chk("hold_err", 32'(err), 32'd0);
    mdl_noise = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
